// File: rtl/h3_ones_gen.sv
// h3_ones_gen: builds a 32-bit word holding a wrapped run of N ones
// starting at bit R, one nibble per cycle (8 cycles per result).
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid, in_ready   request handshake (ready only in IDLE)
//   cnt_in[5:0]          requested ones count, saturated to 32
//   rot_in[4:0]          bit position of the first one
//   out_valid, out_ready result handshake (valid only in HOLD)
//   out_word[31:0]       generated word
//   out_cnt[5:0]         saturated count used, popcount(out_word)
//   err                  cnt_in exceeded 32 for this result
module h3_ones_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  cnt_in,
  input  logic [4:0]  rot_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [5:0]  out_cnt,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUILD = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic [2:0]  k;
  logic [5:0]  n;
  logic [4:0]  r;
  logic        e;
  logic [31:0] build;
  logic [3:0]  nib;

  logic        over;
  logic [5:0]  n_sat;
  logic        last;

  assign over  = cnt_in > 6'd32;
  assign n_sat = over ? 6'd32 : cnt_in;
  assign last  = k == 3'd7;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = BUILD;
      end
      BUILD: begin
        if (last) state_nx = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Offset of bit p from the run start wraps in 5 bits; the
  // compare is 6-bit so n=32 lights every bit.
  logic [4:0] p;
  logic [4:0] d;

  always_comb begin
    nib = '0;
    p   = '0;
    d   = '0;
    for (int j = 0; j < 4; j++) begin
      p      = {k, 2'(j)};
      d      = p - r;
      nib[j] = {1'b0, d} < n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k        <= '0;
      n        <= '0;
      r        <= '0;
      e        <= 1'b0;
      build    <= '0;
      out_word <= '0;
      out_cnt  <= '0;
      err      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            n     <= n_sat;
            r     <= rot_in;
            e     <= over;
            build <= '0;
            k     <= '0;
          end
        end
        BUILD: begin
          build[{k, 2'b00} +: 4] <= nib;
          k <= k + 3'd1;
          // Top nibble is still combinational on the last
          // cycle, so splice it in directly.
          if (last) begin
            out_word <= {nib, build[27:0]};
            out_cnt  <= n;
            err      <= e;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_h3_ones_gen.sv
// tb_h3_ones_gen: randomized and directed checks of h3_ones_gen
// against a run-placement reference model.
module tb_h3_ones_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  cnt_in;
  logic [4:0]  rot_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [5:0]  out_cnt;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  h3_ones_gen dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cnt_in    (cnt_in),
    .rot_in    (rot_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_cnt   (out_cnt),
    .err       (err)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Place n ones one by one starting at r, wrapping at 32.
  function automatic logic [31:0] model_word(int n, int r);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w[(r + i) % 32] = 1'b1;
    return w;
  endfunction

  task automatic req(input int c, input int ro,
                     input int bp, input bit pre);
    int          t;
    int          lat;
    int          ns;
    logic [31:0] ew;
    logic [31:0] snap;
    ns = (c > 32) ? 32 : c;
    ew = model_word(ns, ro);
    @(negedge clk);
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    cnt_in    = 6'(c);
    rot_in    = 5'(ro);
    out_ready = pre;
    @(posedge clk);
    lat = 0;
    forever begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid || lat >= 20) break;
      @(posedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'd8);
    check("out_word", out_word, ew);
    check("out_cnt", 32'(out_cnt), 32'(ns));
    check("err", 32'(err), 32'(c > 32));
    check("loopback", 32'($countones(out_word)), 32'(out_cnt));
    snap = out_word;
    for (int i = 0; i < bp; i++) begin
      in_valid = i[0];
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_word", out_word, snap);
      check("bp_ready", 32'(in_ready), 32'd0);
    end
    // Request alongside consume must not be taken this edge.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("rel_valid", 32'(out_valid), 32'd0);
    check("rel_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int c;
    int ro;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cnt_in    = '0;
    rot_in    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_word", out_word, 32'h0);
    check("rst_out_cnt", 32'(out_cnt), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    req(0, 0, 0, 0);
    check("n0", out_word, 32'h00000000);
    req(5, 0, 0, 1);
    check("n5r0", out_word, 32'h0000001F);
    req(5, 8, 0, 0);
    check("n5r8", out_word, 32'h00001F00);
    req(4, 30, 0, 1);
    check("wrap", out_word, 32'hC0000003);
    req(32, 17, 0, 0);
    check("full", out_word, 32'hFFFFFFFF);
    req(40, 3, 0, 0);
    check("sat_word", out_word, 32'hFFFFFFFF);
    check("sat_err", 32'(err), 32'd1);
    req(1, 9, 0, 0);
    check("err_clr", 32'(err), 32'd0);
    req(7, 27, 5, 0);

    @(negedge clk);
    in_valid = 1'b1;
    cnt_in   = 6'd12;
    rot_in   = 5'd4;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_in_ready", 32'(in_ready), 32'd1);
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_out_word", out_word, 32'h0);
    repeat (10) @(negedge clk);
    check("mid_stay_idle", 32'(out_valid), 32'd0);

    for (int i = 0; i < 100; i++) begin
      c  = int'($urandom_range(0, 40));
      if ($urandom_range(0, 9) == 0) c = int'($urandom_range(33, 63));
      ro = int'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1)
        req(c, ro, 0, 1);
      else
        req(c, ro, int'($urandom_range(0, 2)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
